// File: rtl/dec2bin_pkg.sv
// Shared types and constants for the serial BCD-to-signed-binary converter.
//   state_t  : converter FSM state encoding
//   BCD_MAX  : largest legal BCD digit value
package dec2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/dec2bin_s_if.sv
// Digit-in / result-out bundle for dec2bin_s.
//   master : digit producer and result consumer (drives start/neg/d_valid/digit/d_last/y_ready)
//   slave  : the converter (drives d_ready/y/y_valid/ovf/err)
interface dec2bin_s_if #(
    parameter int W = 8
);
    logic         start;
    logic         neg;
    logic         d_valid;
    logic         d_ready;
    logic [3:0]   digit;
    logic         d_last;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         ovf;
    logic         err;

    modport master (
        output start, neg, d_valid, digit, d_last, y_ready,
        input  d_ready, y, y_valid, ovf, err
    );

    modport slave (
        input  start, neg, d_valid, digit, d_last, y_ready,
        output d_ready, y, y_valid, ovf, err
    );
endinterface

// File: rtl/dec2bin_s_mpy_10.sv
// Shift-add multiply by ten: o_p = i_a*8 + i_a*2.
//   i_a : W-bit unsigned operand
//   o_p : W+4-bit unsigned product (wide enough for 10 * (2^W - 1))
module mpy_10_s #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    output logic [W+3:0] o_p
);

    assign o_p = {1'b0, i_a, 3'b000} + {3'b000, i_a, 1'b0};

endmodule

// File: rtl/dec2bin_s.sv
// Serial BCD-digit to saturated signed binary converter.
// Digits arrive most-significant first; each accepted beat does acc = acc*10 + digit
// on an unsigned magnitude that is clamped at the sign-dependent limit.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dec2bin_s_if slave (start/neg/digit stream in, y/ovf/err result out)
//
// state | meaning
// IDLE  | waiting for start, d_ready low
// ACCUM | accepting digits, d_ready high
// DONE  | result presented, held until y_ready
module dec2bin_s
    import dec2bin_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    dec2bin_s_if.slave  bus
);

    localparam int NW = W + 5;
    localparam logic [NW-1:0] LIM_POS = NW'((1 << (W - 1)) - 1);
    localparam logic [NW-1:0] LIM_NEG = NW'(1 << (W - 1));

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_acc;
    logic           r_neg;
    logic           r_ovf;
    logic           r_err;
    logic [W-1:0]   r_y;
    logic           r_y_valid;

    logic [NW-1:0]  w_prod;
    logic [NW-1:0]  w_nxt;
    logic [NW-1:0]  w_lim;
    logic           w_bad_digit;
    logic           w_sat;
    logic [W-1:0]   w_acc_new;
    logic           w_d_ready;

    mpy_10_s #(.W(W + 1)) u_mpy_10 (
        .i_a ({1'b0, r_acc}),
        .o_p (w_prod)
    );

    // Datapath: next magnitude, clamp limit, and the accumulator value a beat would leave.
    always_comb begin
        w_nxt       = w_prod + NW'(bus.digit);
        w_lim       = r_neg ? LIM_NEG : LIM_POS;
        w_bad_digit = (bus.digit > BCD_MAX);
        w_sat       = (w_nxt > w_lim);
        w_acc_new   = w_nxt[W-1:0];
        if (w_bad_digit) begin
            w_acc_new = r_acc;
        end else if (w_sat) begin
            w_acc_new = w_lim[W-1:0];
        end
    end

    // Next-state logic; start in ACCUM restarts and stays in ACCUM, start in DONE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = ACCUM;
            ACCUM:   if (!bus.start && bus.d_valid && bus.d_last) w_state_nxt = DONE;
            DONE:    if (bus.y_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore outputs.
    always_comb begin
        w_d_ready = (r_state == ACCUM);
    end

    assign bus.d_ready = w_d_ready;
    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.ovf     = r_ovf;
    assign bus.err     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_neg <= bus.neg;
                        r_ovf <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_neg <= bus.neg;
                        r_ovf <= 1'b0;
                        r_err <= 1'b0;
                    end else if (bus.d_valid) begin
                        r_acc <= w_acc_new;
                        if (w_bad_digit) begin
                            r_err <= 1'b1;
                        end else if (w_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (bus.d_last) begin
                            r_y       <= r_neg ? (-w_acc_new) : w_acc_new;
                            r_y_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.y_ready) begin
                        r_y_valid <= 1'b0;
                    end
                end
                default: begin
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
